// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction-memory loader: CPU run state and loader FSM.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package imem_loader_pkg;

   // CPU-wide run state seen by every pipeline stage.
   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_EXEC = 1'b1;

   localparam int IMEM_DEPTH = 256;

   typedef enum logic [1:0] {
      LD_HI    = 2'd0,   // expecting high byte of next word
      LD_LO    = 2'd1,   // expecting low byte, hi_byte holds the high half
      LD_READY = 2'd2,   // program loaded, waiting for start
      LD_RUN   = 2'd3    // CPU executing
   } ld_fsm_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: 2**ADDR_W x DATA_W array, async read, sync write.
// Latency: read is combinational; write lands on the posedge.
// Backpressure: none; always accepts a write.
// Ports: clock; we/waddr/wdata write port; raddr/rdata read port.
module imem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // No reset: contents survive a reset so a partial load is not lost.
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Same-cycle write and read of one address returns the old word.
   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory for fetch plus boot loader that streams bytes in and starts the CPU.
// Latency: fetch read is combinational; a loaded word is readable the cycle after its low byte.
// Backpressure: ld_ready high only in the two load states; bytes are refused in READY/RUN.
// Ports: clock, reset (sync, active-low); i_addr/i_datain fetch port;
//        ld_valid/ld_byte/ld_last/ld_ready host byte stream; start/stop control;
//        state CPU run state; load_count words written; load_err sticky load error.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_datain,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              start,
   input  logic              stop,
   output logic              state,
   output logic [ADDR_W:0]   load_count,
   output logic              load_err
);

   ld_fsm_t           fsm;
   logic [ADDR_W:0]   wr_ptr;     // one extra bit so it saturates at 2**ADDR_W instead of wrapping
   logic [7:0]        hi_byte;
   logic              we;
   logic [DATA_W-1:0] wdata;

   assign ld_ready = (fsm == LD_HI) || (fsm == LD_LO);

   // Every completed word bumps both pointer and count together, so they are the same register.
   assign load_count = wr_ptr;

   // A stop on the same cycle as a low byte restarts the load, so that byte is dropped.
   assign we    = reset && !stop && (fsm == LD_LO) && ld_valid && !wr_ptr[ADDR_W];
   assign wdata = {hi_byte, ld_byte};

   always_ff @(posedge clock) begin
      if (!reset) begin
         fsm      <= LD_HI;
         wr_ptr   <= '0;
         load_err <= 1'b0;
         hi_byte  <= '0;
         state    <= STATE_IDLE;
      end else if (stop) begin
         // Stop beats start and restarts the load from any state.
         fsm      <= LD_HI;
         wr_ptr   <= '0;
         load_err <= 1'b0;
         state    <= STATE_IDLE;
      end else begin
         case (fsm)
            LD_HI: begin
               if (ld_valid) begin
                  hi_byte <= ld_byte;
                  if (ld_last) begin
                     // Program ended on a half word: drop it and flag.
                     load_err <= 1'b1;
                     fsm      <= LD_READY;
                  end else begin
                     fsm <= LD_LO;
                  end
               end
            end
            LD_LO: begin
               if (ld_valid) begin
                  if (!wr_ptr[ADDR_W]) begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end else begin
                     load_err <= 1'b1;
                  end
                  fsm <= ld_last ? LD_READY : LD_HI;
               end
            end
            LD_READY: begin
               if (start) begin
                  fsm   <= LD_RUN;
                  state <= STATE_EXEC;
               end
            end
            default: begin
               state <= STATE_EXEC;
            end
         endcase
      end
   end

   imem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clock (clock),
      .we    (we),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (wdata),
      .raddr (i_addr),
      .rdata (i_datain)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, start/stop, overflow, short program, reset, fetch sweep.
// Inputs change 1 time unit after posedge; outputs are sampled 1 time unit after posedge.
// Each scenario is its own task with inline comparisons.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clock;
   logic        reset;
   logic [7:0]  i_addr;
   logic [15:0] i_datain;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_last;
   logic        ld_ready;
   logic        start;
   logic        stop;
   logic        state;
   logic [8:0]  load_count;
   logic        load_err;

   int n_checks = 0;
   int n_fail   = 0;

   imem_loader dut (
      .clock      (clock),
      .reset      (reset),
      .i_addr     (i_addr),
      .i_datain   (i_datain),
      .ld_valid   (ld_valid),
      .ld_byte    (ld_byte),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .start      (start),
      .stop       (stop),
      .state      (state),
      .load_count (load_count),
      .load_err   (load_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one byte, wait (bounded) for ld_ready, let it transfer on the next edge.
   task automatic send_byte(input logic [7:0] b, input logic last);
      int waitc;
      waitc    = 0;
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      while (!ld_ready && waitc < 16) begin
         tick();
         waitc++;
      end
      if (!ld_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_byte_ready: ld_ready=%b required 1", ld_ready);
      end
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b required 1", ld_ready); end
      n_checks++; if (state !== STATE_IDLE) begin n_fail++; $display("FAIL reset_state: got %b required %b", state, STATE_IDLE); end
      n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL reset_load_count: got %0d required 0", load_count); end
      n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %b required 0", load_err); end
   endtask

   task automatic test_basic_load();
      logic [7:0]  bytes [6];
      logic [15:0] exp [3];
      bytes = '{8'h40, 8'h12, 8'h48, 8'h34, 8'h08, 8'h00};
      exp   = '{16'h4012, 16'h4834, 16'h0800};
      for (int i = 0; i < 6; i++) send_byte(bytes[i], i == 5);
      n_checks++; if (load_count !== 9'd3) begin n_fail++; $display("FAIL basic_load_count: got %0d required 3", load_count); end
      n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL basic_load_err: got %b required 0", load_err); end
      n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_after_last: got %b required 0", ld_ready); end
      n_checks++; if (state !== STATE_IDLE) begin n_fail++; $display("FAIL basic_state_before_start: got %b required %b", state, STATE_IDLE); end
      pulse_start();
      n_checks++; if (state !== STATE_EXEC) begin n_fail++; $display("FAIL basic_state_exec: got %b required %b", state, STATE_EXEC); end
      for (int a = 0; a < 3; a++) begin
         i_addr = 8'(a);
         #1;
         n_checks++;
         if (i_datain !== exp[a]) begin n_fail++; $display("FAIL basic_read[%0d]: got %h required %h", a, i_datain, exp[a]); end
      end
      pulse_stop();
      n_checks++; if (state !== STATE_IDLE) begin n_fail++; $display("FAIL basic_stop_state: got %b required %b", state, STATE_IDLE); end
      n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL basic_stop_count: got %0d required 0", load_count); end
   endtask

   task automatic test_short_last();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'hAB, 1'b1);
      n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL short_load_err: got %b required 1", load_err); end
      n_checks++; if (load_count !== 9'd1) begin n_fail++; $display("FAIL short_load_count: got %0d required 1", load_count); end
      n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL short_ld_ready: got %b required 0", ld_ready); end
      i_addr = 8'd0;
      #1;
      n_checks++; if (i_datain !== 16'h1122) begin n_fail++; $display("FAIL short_mem0: got %h required 1122", i_datain); end
      // mem[1] still holds the earlier 0x4834; the dangling 0xAB must not reach it.
      i_addr = 8'd1;
      #1;
      n_checks++; if (i_datain !== 16'h4834) begin n_fail++; $display("FAIL short_mem1: got %h required 4834", i_datain); end
      pulse_stop();
      n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL short_restart_err: got %b required 0", load_err); end
   endtask

   task automatic test_overflow();
      logic [15:0] w;
      for (int n = 0; n < 257; n++) begin
         w = 16'h1000 + 16'(n);
         send_byte(w[15:8], 1'b0);
         send_byte(w[7:0], n == 256);
         if (n == 255) begin
            n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL ovf_count_at_256: got %0d required 256", load_count); end
            n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_at_256: got %b required 0", load_err); end
         end
      end
      n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL ovf_count: got %0d required 256", load_count); end
      n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b required 1", load_err); end
      i_addr = 8'd0;
      #1;
      n_checks++; if (i_datain !== 16'h1000) begin n_fail++; $display("FAIL ovf_mem0: got %h required 1000", i_datain); end
      i_addr = 8'd255;
      #1;
      n_checks++; if (i_datain !== 16'h10FF) begin n_fail++; $display("FAIL ovf_mem255: got %h required 10ff", i_datain); end
   endtask

   // Entered in READY (left there by test_overflow).
   task automatic test_start_stop();
      ld_valid = 1'b1;
      ld_byte  = 8'h55;
      pulse_start();
      n_checks++; if (state !== STATE_EXEC) begin n_fail++; $display("FAIL ss_state_exec: got %b required %b", state, STATE_EXEC); end
      n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL ss_no_accept: got %0d required 256", load_count); end
      n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL ss_ready_run: got %b required 0", ld_ready); end
      tick();
      n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL ss_no_accept_run: got %0d required 256", load_count); end
      ld_valid = 1'b0;
      pulse_stop();
      n_checks++; if (state !== STATE_IDLE) begin n_fail++; $display("FAIL ss_stop_state: got %b required %b", state, STATE_IDLE); end
      n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL ss_stop_ready: got %b required 1", ld_ready); end
      n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL ss_stop_count: got %0d required 0", load_count); end
      n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL ss_stop_err: got %b required 0", load_err); end
   endtask

   task automatic test_reset_midload();
      send_byte(8'hCA, 1'b0);
      send_byte(8'hFE, 1'b0);
      send_byte(8'h77, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      i_addr = 8'd0;
      #1;
      n_checks++; if (i_datain !== 16'hCAFE) begin n_fail++; $display("FAIL rst_mem0_kept: got %h required cafe", i_datain); end
      i_addr = 8'd1;
      #1;
      n_checks++; if (i_datain !== 16'h1001) begin n_fail++; $display("FAIL rst_mem1_untouched: got %h required 1001", i_datain); end
      n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", ld_ready); end
      n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", load_count); end
      n_checks++; if (state !== STATE_IDLE) begin n_fail++; $display("FAIL rst_state: got %b required %b", state, STATE_IDLE); end
      // If the half word survived reset, 0xBE would be taken as a low byte.
      send_byte(8'hBE, 1'b0);
      send_byte(8'hEF, 1'b1);
      i_addr = 8'd0;
      #1;
      n_checks++; if (i_datain !== 16'hBEEF) begin n_fail++; $display("FAIL rst_reload_mem0: got %h required beef", i_datain); end
      n_checks++; if (load_count !== 9'd1) begin n_fail++; $display("FAIL rst_reload_count: got %0d required 1", load_count); end
      pulse_stop();
   endtask

   task automatic test_run_sweep();
      logic [15:0] w;
      int          bad;
      for (int n = 0; n < 256; n++) begin
         w = {8'(n) ^ 8'h5A, 8'(n)};
         send_byte(w[15:8], 1'b0);
         send_byte(w[7:0], n == 255);
      end
      pulse_start();
      bad = 0;
      for (int n = 0; n < 256; n++) begin
         i_addr   = 8'(n);
         ld_valid = n[0];
         ld_byte  = 8'hEE;
         #1;
         w = {8'(n) ^ 8'h5A, 8'(n)};
         n_checks++;
         if (i_datain !== w) begin
            n_fail++;
            if (bad < 4) $display("FAIL sweep_read[%0d]: got %h required %h", n, i_datain, w);
            bad++;
         end
         @(posedge clock);
         #1;
      end
      ld_valid = 1'b0;
      n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL sweep_count: got %0d required 256", load_count); end
      n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL sweep_err: got %b required 0", load_err); end
      n_checks++; if (state !== STATE_EXEC) begin n_fail++; $display("FAIL sweep_state: got %b required %b", state, STATE_EXEC); end
      n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL sweep_ready: got %b required 0", ld_ready); end
   endtask

   initial begin
      reset    = 1'b0;
      i_addr   = '0;
      ld_valid = 1'b0;
      ld_byte  = '0;
      ld_last  = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      test_reset();
      test_basic_load();
      test_short_last();
      test_overflow();
      test_start_stop();
      test_reset_midload();
      test_run_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
